// File: rtl/interleaver_read_ctrl.sv
// Read-side address generator for the interleaver block buffer: streams the LTE QPP
// permutation pi(i) = (F1*i + F2*i^2) mod K over a valid/ready interface.
module interleaver_read_ctrl #(
  parameter int ADDR_W   = 13,
  parameter int K_SMALL  = 1056,
  parameter int K_LARGE  = 6144,
  parameter int F1_SMALL = 17,
  parameter int F2_SMALL = 66,
  parameter int F1_LARGE = 263,
  parameter int F2_LARGE = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              block_size,
  output logic              busy,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              done,
  output logic [1:0]        dbg_state
);

  // Stream handshake: a transfer happens on a rising edge where rd_valid && rd_ready.
  // While rd_valid is high and rd_ready low, rd_addr/rd_last/i hold; rd_valid only
  // drops after the transfer flagged by rd_last.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1
  } state_t;

  // First increment g(0) = pi(1) - pi(0) and second difference 2*F2, both reduced mod K.
  localparam logic [ADDR_W-1:0] K_S   = ADDR_W'(K_SMALL);
  localparam logic [ADDR_W-1:0] K_L   = ADDR_W'(K_LARGE);
  localparam logic [ADDR_W-1:0] G0_S  = ADDR_W'((F1_SMALL + F2_SMALL) % K_SMALL);
  localparam logic [ADDR_W-1:0] G0_L  = ADDR_W'((F1_LARGE + F2_LARGE) % K_LARGE);
  localparam logic [ADDR_W-1:0] D_S   = ADDR_W'((2 * F2_SMALL) % K_SMALL);
  localparam logic [ADDR_W-1:0] D_L   = ADDR_W'((2 * F2_LARGE) % K_LARGE);

  state_t            state;
  logic [ADDR_W-1:0] i_cnt;
  logic [ADDR_W-1:0] pi;
  logic [ADDR_W-1:0] g;
  logic [ADDR_W-1:0] k_reg;
  logic [ADDR_W-1:0] k_m1;
  logic [ADDR_W-1:0] d_reg;
  logic [ADDR_W-1:0] i_next;

  // Both operands are already < K, so a single conditional subtract reduces the sum.
  function automatic logic [ADDR_W-1:0] mod_add(input logic [ADDR_W-1:0] a,
                                                input logic [ADDR_W-1:0] b,
                                                input logic [ADDR_W-1:0] k);
    logic [ADDR_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= {1'b0, k}) sum = sum - {1'b0, k};
    return sum[ADDR_W-1:0];
  endfunction

  assign i_next    = i_cnt + 1'b1;
  assign rd_addr   = pi;
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
      i_cnt    <= '0;
      pi       <= '0;
      g        <= '0;
      k_reg    <= '0;
      k_m1     <= '0;
      d_reg    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            rd_valid <= 1'b1;
            rd_last  <= 1'b0;
            i_cnt    <= '0;
            pi       <= '0;
            if (block_size) begin
              k_reg <= K_L;
              k_m1  <= K_L - 1'b1;
              g     <= G0_L;
              d_reg <= D_L;
            end else begin
              k_reg <= K_S;
              k_m1  <= K_S - 1'b1;
              g     <= G0_S;
              d_reg <= D_S;
            end
          end
        end
        RUN: begin
          if (rd_valid && rd_ready) begin
            if (rd_last) begin
              state    <= IDLE;
              busy     <= 1'b0;
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
              done     <= 1'b1;
            end else begin
              i_cnt   <= i_next;
              pi      <= mod_add(pi, g, k_reg);
              g       <= mod_add(g, d_reg, k_reg);
              rd_last <= (i_next == k_m1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_interleaver_read_ctrl.sv
// Directed bench for interleaver_read_ctrl: full small/large blocks, backpressure,
// ignored start/block_size during a block, and mid-block asynchronous reset.
module tb_interleaver_read_ctrl;

  localparam int ADDR_W = 13;

  logic              clk;
  logic              reset;
  logic              start;
  logic              block_size;
  logic              busy;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              rd_ready;
  logic              rd_last;
  logic              done;
  logic [1:0]        dbg_state;

  int errors = 0;
  int checks = 0;
  int seen[8192];

  interleaver_read_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .block_size(block_size),
    .busy      (busy),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_last   (rd_last),
    .done      (done),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference permutation computed directly from the closed-form QPP polynomial.
  function automatic logic [31:0] qpp(input int k, input int f1, input int f2, input int idx);
    longint v;
    v = longint'(f1) * idx + longint'(f2) * idx * idx;
    return 32'(v % k);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a block from IDLE and follows it to the done cycle (or to the abort point).
  task automatic run_block(input bit bs, input bit bp, input bit disturb, input int abort_at);
    int k, f1, f2, idx, cyc;
    bit xfer, aborted;
    logic [31:0] exp_last;
    k        = bs ? 6144 : 1056;
    f1       = bs ? 263 : 17;
    f2       = bs ? 480 : 66;
    exp_last = bs ? 32'd217 : 32'd49;
    aborted  = 1'b0;
    for (int a = 0; a < 8192; a++) seen[a] = 0;
    start      = 1'b1;
    block_size = bs;
    rd_ready   = 1'b1;
    tick();
    start = 1'b0;
    check("first_done_low", 32'(done), 32'd0);
    check("first_valid", 32'(rd_valid), 32'd1);
    check("first_busy", 32'(busy), 32'd1);
    check("first_addr", 32'(rd_addr), 32'd0);
    idx = 0;
    cyc = 0;
    while (idx < k && cyc < 20 * k) begin
      if (idx == abort_at) begin
        reset = 1'b0;
        #1;
        check("abort_valid", 32'(rd_valid), 32'd0);
        check("abort_addr", 32'(rd_addr), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_last", 32'(rd_last), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_state", 32'(dbg_state), 32'd0);
        aborted = 1'b1;
        break;
      end
      rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (disturb) begin
        start      = (idx >= 100 && idx < 110);
        block_size = (idx >= 100 && idx < 400) ? ~bs : bs;
      end
      check("valid", 32'(rd_valid), 32'd1);
      check("busy", 32'(busy), 32'd1);
      check("addr", 32'(rd_addr), qpp(k, f1, f2, idx));
      check("last", 32'(rd_last), 32'(idx == k - 1));
      check("range", 32'(int'(rd_addr) < k), 32'd1);
      if (idx == k - 1) check("last_addr", 32'(rd_addr), exp_last);
      xfer = rd_ready;
      if (xfer) seen[rd_addr]++;
      tick();
      cyc++;
      if (xfer) idx++;
    end
    start      = 1'b0;
    block_size = bs;
    if (!aborted) begin
      check("block_complete", 32'(idx), 32'(k));
      check("done_pulse", 32'(done), 32'd1);
      check("end_valid", 32'(rd_valid), 32'd0);
      check("end_busy", 32'(busy), 32'd0);
      check("end_last", 32'(rd_last), 32'd0);
      for (int a = 0; a < k; a++) check("perm_once", 32'(seen[a]), 32'd1);
    end
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    block_size = 1'b0;
    rd_ready   = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);
    check("rst_last", 32'(rd_last), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b1;
    tick();
    check("idle_valid", 32'(rd_valid), 32'd0);

    // Small block, then a new start issued in the done cycle.
    run_block(1'b0, 1'b0, 1'b0, -1);
    run_block(1'b0, 1'b0, 1'b0, -1);
    tick();
    check("done_one_cycle", 32'(done), 32'd0);

    // Large block.
    run_block(1'b1, 1'b0, 1'b0, -1);
    tick();

    // Random backpressure on a small block.
    run_block(1'b0, 1'b1, 1'b0, -1);
    tick();

    // start pulses and block_size toggles during a small block.
    run_block(1'b0, 1'b0, 1'b1, -1);
    repeat (5) begin
      tick();
      check("no_extra_valid", 32'(rd_valid), 32'd0);
      check("no_extra_busy", 32'(busy), 32'd0);
    end

    // Reset at transfer 500 of a large block, then a fresh small block.
    run_block(1'b1, 1'b0, 1'b0, 500);
    repeat (2) begin
      tick();
      check("rst_hold_valid", 32'(rd_valid), 32'd0);
      check("rst_hold_done", 32'(done), 32'd0);
    end
    reset = 1'b1;
    repeat (3) begin
      tick();
      check("post_rst_valid", 32'(rd_valid), 32'd0);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_state", 32'(dbg_state), 32'd0);
    end
    run_block(1'b0, 1'b0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
